sap1_controller_sequencer: RTL and testbench

//   Control/sequencer for the 8-bit SAP-1 datapath: PC, MAR, RAM, IR, A/B regs, adder/subtractor, output reg.

---
 rtl/sap1_pkg.sv | 37 +++
 rtl/sap1_controller_sequencer_if.sv | 24 ++
 rtl/sap1_ring_counter.sv | 32 +++
 rtl/sap1_controller_sequencer.sv | 97 +++++++++
 tb/tb_sap1_controller_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller/sequencer: opcodes, T-state indices
// and the bit layout of the packed control word.
package sap1_pkg;

    localparam int unsigned OPC_NIB_W = 4;
    localparam int unsigned T_W       = 6;
    localparam int unsigned CW_W      = 12;

    localparam logic [OPC_NIB_W-1:0] OPC_LDA = 4'h0;
    localparam logic [OPC_NIB_W-1:0] OPC_ADD = 4'h1;
    localparam logic [OPC_NIB_W-1:0] OPC_SUB = 4'h2;
    localparam logic [OPC_NIB_W-1:0] OPC_OUT = 4'hE;
    localparam logic [OPC_NIB_W-1:0] OPC_HLT = 4'hF;

    localparam int unsigned T1 = 0;
    localparam int unsigned T2 = 1;
    localparam int unsigned T3 = 2;
    localparam int unsigned T4 = 3;
    localparam int unsigned T5 = 4;
    localparam int unsigned T6 = 5;

    localparam int unsigned CW_CP = 0;
    localparam int unsigned CW_EP = 1;
    localparam int unsigned CW_LM = 2;
    localparam int unsigned CW_CE = 3;
    localparam int unsigned CW_LI = 4;
    localparam int unsigned CW_EI = 5;
    localparam int unsigned CW_LA = 6;
    localparam int unsigned CW_EA = 7;
    localparam int unsigned CW_SU = 8;
    localparam int unsigned CW_EU = 9;
    localparam int unsigned CW_LB = 10;
    localparam int unsigned CW_LO = 11;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/sap1_controller_sequencer_if.sv
// Sequencer-to-datapath bundle: mode/opcode inputs, T-state, status and control strobes.
interface sap1_controller_sequencer_if #(
    parameter int unsigned OPC_W = 4
);
    logic             run;
    logic             step;
    logic [OPC_W-1:0] opcode;
    logic [5:0]       t_state;
    logic             halted;
    logic             clr_out;
    logic             cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    modport master (
        input  run, step, opcode,
        output t_state, halted, clr_out,
        output cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );

    modport slave (
        output run, step, opcode,
        input  t_state, halted, clr_out,
        input  cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
    );
endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T1..T6 ring counter with hold, rotate and synchronous jump back to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic           clk,
    input  logic           clr_n,
    input  logic           adv,
    input  logic           restart,
    output logic [T_W-1:0] t_state
);

    localparam logic [T_W-1:0] T1_OH = T_W'(1);

    logic [T_W-1:0] state_q;
    logic [T_W-1:0] state_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= T1_OH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (restart)  state_d = T1_OH;
        else if (adv) state_d = {state_q[T_W-2:0], state_q[T_W-1]};
    end

    always_comb begin
        t_state = state_q;
    end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 control/sequencer: T-state ring, opcode decode into one control word per
// advancing cycle, free-run/single-step gating and sticky halt.
module sap1_controller_sequencer
    import sap1_pkg::*;
#(
    parameter int unsigned OPC_W    = 4,
    parameter bit          SKIP_NOP = 1'b0
) (
    input  logic                        clk,
    input  logic                        clr_n,
    sap1_controller_sequencer_if.master bus
);

    logic [T_W-1:0]       t_state;
    logic [OPC_NIB_W-1:0] op_nib;
    logic                 halted_q;
    logic                 clr_out_q;
    logic                 advance_c;
    logic                 hlt_hit_c;
    logic                 short_op_c;
    logic                 restart_c;
    ctrl_word_t           cw_dec;
    ctrl_word_t           cw_c;

    assign op_nib    = OPC_NIB_W'(bus.opcode);
    assign advance_c = ~halted_q & ~clr_out_q & (bus.run | bus.step);

    // HLT freezes the ring on the very edge it is decoded in T4
    assign hlt_hit_c  = advance_c & t_state[T4] & (op_nib == OPC_HLT);
    assign short_op_c = (op_nib != OPC_ADD) & (op_nib != OPC_SUB)
                      & (op_nib != OPC_LDA) & (op_nib != OPC_HLT);
    assign restart_c  = SKIP_NOP & advance_c &
                        ((t_state[T5] & (op_nib == OPC_LDA)) | (t_state[T4] & short_op_c));

    sap1_ring_counter u_ring (
        .clk     (clk),
        .clr_n   (clr_n),
        .adv     (advance_c & ~hlt_hit_c),
        .restart (restart_c),
        .t_state (t_state)
    );

    // clr_out is asserted during reset and drops on the first edge after release
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            clr_out_q <= 1'b1;
            halted_q  <= 1'b0;
        end else begin
            clr_out_q <= 1'b0;
            if (hlt_hit_c) halted_q <= 1'b1;
        end
    end

    always_comb begin
        cw_dec = '0;
        casez ({t_state, op_nib})
            {6'b000001, 4'b????}: begin cw_dec[CW_EP] = 1'b1; cw_dec[CW_LM] = 1'b1; end
            {6'b000010, 4'b????}: begin cw_dec[CW_CP] = 1'b1; end
            {6'b000100, 4'b????}: begin cw_dec[CW_CE] = 1'b1; cw_dec[CW_LI] = 1'b1; end
            {6'b001000, OPC_LDA},
            {6'b001000, OPC_ADD},
            {6'b001000, OPC_SUB}: begin cw_dec[CW_EI] = 1'b1; cw_dec[CW_LM] = 1'b1; end
            {6'b001000, OPC_OUT}: begin cw_dec[CW_EA] = 1'b1; cw_dec[CW_LO] = 1'b1; end
            {6'b010000, OPC_LDA}: begin cw_dec[CW_CE] = 1'b1; cw_dec[CW_LA] = 1'b1; end
            {6'b010000, OPC_ADD},
            {6'b010000, OPC_SUB}: begin cw_dec[CW_CE] = 1'b1; cw_dec[CW_LB] = 1'b1; end
            {6'b100000, OPC_ADD}: begin cw_dec[CW_EU] = 1'b1; cw_dec[CW_LA] = 1'b1; end
            {6'b100000, OPC_SUB}: begin
                cw_dec[CW_EU] = 1'b1; cw_dec[CW_LA] = 1'b1; cw_dec[CW_SU] = 1'b1;
            end
            default: cw_dec = '0;
        endcase
    end

    // A stalled cycle must never load a register or count the PC
    always_comb begin
        cw_c = '0;
        if (advance_c) cw_c = cw_dec;
    end

    assign bus.t_state = t_state;
    assign bus.halted  = halted_q;
    assign bus.clr_out = clr_out_q;
    assign bus.cp      = cw_c[CW_CP];
    assign bus.ep      = cw_c[CW_EP];
    assign bus.lm      = cw_c[CW_LM];
    assign bus.ce      = cw_c[CW_CE];
    assign bus.li      = cw_c[CW_LI];
    assign bus.ei      = cw_c[CW_EI];
    assign bus.la      = cw_c[CW_LA];
    assign bus.ea      = cw_c[CW_EA];
    assign bus.su      = cw_c[CW_SU];
    assign bus.eu      = cw_c[CW_EU];
    assign bus.lb      = cw_c[CW_LB];
    assign bus.lo      = cw_c[CW_LO];

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Bench for sap1_controller_sequencer: two instances (SKIP_NOP=0/1) against a
// T-number based reference model of the SAP-1 microcode table.
module tb_sap1_controller_sequencer;

    localparam logic [3:0] LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, OUTP = 4'hE, HLT = 4'hF;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] opcode = 4'h0;

    int n_cmp = 0;
    int n_bad = 0;

    // model state per instance: T number 1..6, halted, clr_out
    int m_t[2];
    bit m_h[2];
    bit m_c[2];

    always #5 clk = ~clk;

    sap1_controller_sequencer_if #(.OPC_W(4)) if0 ();
    sap1_controller_sequencer_if #(.OPC_W(4)) if1 ();

    assign if0.run = run;  assign if0.step = step;  assign if0.opcode = opcode;
    assign if1.run = run;  assign if1.step = step;  assign if1.opcode = opcode;

    sap1_controller_sequencer #(.OPC_W(4), .SKIP_NOP(1'b0)) dut0 (.clk(clk), .clr_n(clr_n), .bus(if0));
    sap1_controller_sequencer #(.OPC_W(4), .SKIP_NOP(1'b1)) dut1 (.clk(clk), .clr_n(clr_n), .bus(if1));

    logic [19:0] obs0, obs1;
    assign obs0 = {if0.t_state, if0.halted, if0.clr_out, if0.cp, if0.ep, if0.lm, if0.ce,
                   if0.li, if0.ei, if0.la, if0.ea, if0.su, if0.eu, if0.lb, if0.lo};
    assign obs1 = {if1.t_state, if1.halted, if1.clr_out, if1.cp, if1.ep, if1.lm, if1.ce,
                   if1.li, if1.ei, if1.la, if1.ea, if1.su, if1.eu, if1.lb, if1.lo};

    function automatic logic [11:0] exp_cw(int t, logic [3:0] op, logic adv);
        logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = '0;
        if (adv) begin
            case (t)
                1: begin ep = 1'b1; lm = 1'b1; end
                2: cp = 1'b1;
                3: begin ce = 1'b1; li = 1'b1; end
                4: if (op == LDA || op == ADD || op == SUB) begin ei = 1'b1; lm = 1'b1; end
                   else if (op == OUTP) begin ea = 1'b1; lo = 1'b1; end
                5: if (op == LDA) begin ce = 1'b1; la = 1'b1; end
                   else if (op == ADD || op == SUB) begin ce = 1'b1; lb = 1'b1; end
                6: if (op == ADD || op == SUB) begin eu = 1'b1; la = 1'b1; su = (op == SUB); end
                default: ;
            endcase
        end
        return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    endfunction

    function automatic logic [19:0] exp_vec(int v);
        logic adv;
        adv = clr_n && !m_c[v] && !m_h[v] && (run || step);
        return {6'(1 << (m_t[v] - 1)), m_h[v], m_c[v], exp_cw(m_t[v], opcode, adv)};
    endfunction

    function automatic bit skips_to_t1(int t, logic [3:0] op);
        bit nop_like;
        nop_like = !(op == LDA || op == ADD || op == SUB || op == HLT);
        return (t == 5 && op == LDA) || (t == 4 && nop_like);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 2; v++) begin m_t[v] = 1; m_h[v] = 1'b0; m_c[v] = 1'b1; end
    endtask

    task automatic drive(input logic r, input logic s, input logic [3:0] op);
        run = r; step = s; opcode = op;
        #1;
    endtask

    task automatic assert_reset();
        clr_n = 1'b0;
        model_reset();
        #1;
    endtask

    // one clock: next model state from the inputs held across the edge
    task automatic clock_edge();
        int nt[2]; bit nh[2]; bit nc[2];
        for (int v = 0; v < 2; v++) begin
            nt[v] = m_t[v]; nh[v] = m_h[v]; nc[v] = m_c[v];
            if (!clr_n) begin
                nt[v] = 1; nh[v] = 1'b0; nc[v] = 1'b1;
            end else if (m_c[v]) begin
                nc[v] = 1'b0;
            end else if (!m_h[v] && (run || step)) begin
                if (m_t[v] == 4 && opcode == HLT) nh[v] = 1'b1;
                else if (v == 1 && skips_to_t1(m_t[v], opcode)) nt[v] = 1;
                else nt[v] = (m_t[v] == 6) ? 1 : m_t[v] + 1;
            end
        end
        @(posedge clk);
        m_t = nt; m_h = nh; m_c = nc;
        #1;
    endtask

    task automatic fresh_start(input logic r, input logic [3:0] op);
        assert_reset();
        clock_edge();
        clr_n = 1'b1;
        drive(r, 1'b0, op);
        clock_edge();
    endtask

    task automatic test_reset();
        assert_reset();
        n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL reset_hold dut0 got %b want %b", obs0, exp_vec(0)); end
        n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL reset_hold dut1 got %b want %b", obs1, exp_vec(1)); end
        clock_edge();
        clr_n = 1'b1;
        drive(1'b1, 1'b0, LDA);
        n_cmp++; if (if0.clr_out !== 1'b1 || if0.ep !== 1'b0) begin n_bad++; $display("FAIL reset_release clr_out=%b ep=%b want 1/0", if0.clr_out, if0.ep); end
        clock_edge();
        n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL reset_t1 dut0 got %b want %b", obs0, exp_vec(0)); end
        n_cmp++; if ({if0.clr_out, if0.ep, if0.lm} !== 3'b011) begin n_bad++; $display("FAIL reset_t1_eplm got %b want 011", {if0.clr_out, if0.ep, if0.lm}); end
    endtask

    task automatic test_lda();
        fresh_start(1'b1, LDA);
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b0, LDA);
            n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL lda[%0d] dut0 got %b want %b", i, obs0, exp_vec(0)); end
            n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL lda[%0d] dut1 got %b want %b", i, obs1, exp_vec(1)); end
            if (i == 6) begin
                n_cmp++; if (if0.t_state !== 6'b000001) begin n_bad++; $display("FAIL lda_wrap got %b want 000001", if0.t_state); end
            end
            clock_edge();
        end
    endtask

    task automatic test_add_sub();
        int su_cnt = 0;
        fresh_start(1'b1, ADD);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, (i < 6) ? ADD : SUB);
            if (if0.su === 1'b1) su_cnt++;
            n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL addsub[%0d] dut0 got %b want %b", i, obs0, exp_vec(0)); end
            n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL addsub[%0d] dut1 got %b want %b", i, obs1, exp_vec(1)); end
            clock_edge();
        end
        n_cmp++; if (su_cnt != 1) begin n_bad++; $display("FAIL addsub_su_cycles got %0d want 1", su_cnt); end
    endtask

    task automatic test_hlt();
        fresh_start(1'b1, HLT);
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1'b0, HLT);
            n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL hlt[%0d] dut0 got %b want %b", i, obs0, exp_vec(0)); end
            n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL hlt[%0d] dut1 got %b want %b", i, obs1, exp_vec(1)); end
            if (i >= 4) begin
                n_cmp++;
                if (obs0 !== {6'b001000, 1'b1, 1'b0, 12'h000}) begin n_bad++; $display("FAIL hlt_frozen[%0d] got %b", i, obs0); end
            end
            clock_edge();
        end
        assert_reset();
        n_cmp++; if ({if0.t_state, if0.halted} !== 7'b0000010) begin n_bad++; $display("FAIL hlt_clear got %b want 0000010", {if0.t_state, if0.halted}); end
        clock_edge();
        clr_n = 1'b1;
    endtask

    task automatic test_step();
        int cp_cnt = 0;
        fresh_start(1'b0, LDA);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, (i % 4) == 0, LDA);
            if (if0.cp === 1'b1) cp_cnt++;
            n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL step[%0d] dut0 got %b want %b", i, obs0, exp_vec(0)); end
            clock_edge();
        end
        drive(1'b0, 1'b0, LDA);
        n_cmp++; if (if0.t_state !== 6'b001000) begin n_bad++; $display("FAIL step_t4 got %b want 001000", if0.t_state); end
        n_cmp++; if (cp_cnt != 1) begin n_bad++; $display("FAIL step_cp_cycles got %0d want 1", cp_cnt); end
    endtask

    task automatic test_skip_nop();
        fresh_start(1'b1, OUTP);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, OUTP);
            n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL skip_out[%0d] dut1 got %b want %b", i, obs1, exp_vec(1)); end
            if (i == 3) begin
                n_cmp++; if ({if1.ea, if1.lo} !== 2'b11) begin n_bad++; $display("FAIL skip_out_t4 ea,lo got %b want 11", {if1.ea, if1.lo}); end
            end
            if (i == 4) begin
                n_cmp++; if (if1.t_state !== 6'b000001) begin n_bad++; $display("FAIL skip_out_t1 got %b want 000001", if1.t_state); end
            end
            clock_edge();
        end
        fresh_start(1'b1, ADD);
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, ADD); clock_edge(); end
        drive(1'b1, 1'b0, ADD);
        n_cmp++; if ({if0.t_state, if0.lb} !== 7'b0100001) begin n_bad++; $display("FAIL midreset_t5 got %b want 0100001", {if0.t_state, if0.lb}); end
        #2;
        assert_reset();
        n_cmp++; if ({if0.t_state, if0.lb, if1.t_state, if1.lb} !== 14'b00000100_000010) begin
            n_bad++; $display("FAIL midreset_t1 got %b want 00000100000010", {if0.t_state, if0.lb, if1.t_state, if1.lb});
        end
        clock_edge();
        clr_n = 1'b1;
    endtask

    task automatic test_random();
        logic [3:0] pick[6] = '{LDA, ADD, SUB, OUTP, HLT, 4'h7};
        for (int i = 0; i < 400; i++) begin
            if (!clr_n) clr_n = 1'b1;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, pick[$urandom_range(0, 5)]);
            if ($urandom_range(0, 29) == 0) assert_reset();
            n_cmp++; if (obs0 !== exp_vec(0)) begin n_bad++; $display("FAIL rand[%0d] dut0 got %b want %b", i, obs0, exp_vec(0)); end
            n_cmp++; if (obs1 !== exp_vec(1)) begin n_bad++; $display("FAIL rand[%0d] dut1 got %b want %b", i, obs1, exp_vec(1)); end
            clock_edge();
        end
        clr_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_lda();
        test_add_sub();
        test_hlt();
        test_step();
        test_skip_nop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
